// File: rtl/mc_control_fsm.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute over the shared-memory datapath.
// Optional retired-instruction counter enabled by defining MC_CTRL_INSTR_CNT_EN.
module mc_control_fsm #(
    parameter int OPC_W = 6,
    parameter int RT_W  = 5
`ifdef MC_CTRL_INSTR_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] opcode,
    input  logic [RT_W-1:0]  rt,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_source,
    output logic [2:0]       alu_op,
    output logic [2:0]       branch_cond,
    output logic             illegal_op,
    output logic [3:0]       state_dbg
`ifdef MC_CTRL_INSTR_CNT_EN
    ,
    output logic [CNT_W-1:0] instr_count
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_WB_R     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_WB_I     = 4'd9,
        S_BRANCH   = 4'd10
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_run;
    logic        w_is_lw, w_is_sw, w_is_r, w_is_addi, w_is_andi, w_is_ori;
    logic        w_is_br, w_is_ialu;
    logic [2:0]  w_bc;
    logic [2:0]  w_aop;
    logic        w_pc_write, w_pc_write_cond, w_iord, w_mem_read, w_mem_write, w_ir_write;
    logic        w_reg_dst, w_mem_to_reg, w_reg_write, w_alu_src_a, w_illegal;
    logic [1:0]  w_alu_src_b, w_pc_source;
    logic [2:0]  w_alu_op, w_branch_cond;

    assign w_is_lw   = (opcode == 6'b100011);
    assign w_is_sw   = (opcode == 6'b101011);
    assign w_is_r    = (opcode == 6'b000000);
    assign w_is_addi = (opcode == 6'b001000);
    assign w_is_andi = (opcode == 6'b001100);
    assign w_is_ori  = (opcode == 6'b001101);
    assign w_is_ialu = w_is_addi | w_is_andi | w_is_ori;
    assign w_is_br   = (w_bc != 3'b000);

    // Branch condition per opcode; bgtz/bltz are only legal with their rt qualifier.
    always_comb begin
        w_bc = 3'b000;
        case (opcode)
            6'b000100: w_bc = 3'b001;
            6'b000101: w_bc = 3'b010;
            6'b000001: w_bc = 3'b011;
            6'b000110: w_bc = 3'b101;
            6'b000111: begin
                if (rt == 5'b00001) w_bc = 3'b100;
                else                w_bc = 3'b000;
            end
            6'b000011: begin
                if (rt == 5'b00000) w_bc = 3'b110;
                else                w_bc = 3'b000;
            end
            default:   w_bc = 3'b000;
        endcase
    end

    // ALU operation per opcode, held for the whole instruction after FETCH.
    always_comb begin
        w_aop = 3'b000;
        case (opcode)
            6'b000000: w_aop = 3'b010;
            6'b001000: w_aop = 3'b011;
            6'b001100: w_aop = 3'b100;
            6'b001101: w_aop = 3'b101;
            default: begin
                if (w_is_br) w_aop = 3'b001;
                else         w_aop = 3'b000;
            end
        endcase
    end

    // Next-state and control decode from the state register and opcode.
    always_comb begin
        w_next          = r_state;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_dst       = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_pc_source     = 2'b00;
        w_alu_op        = 3'b000;
        w_branch_cond   = 3'b000;
        w_illegal       = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                w_alu_src_b   = 2'b11;
                w_alu_op      = w_aop;
                w_branch_cond = w_bc;
                if (w_is_lw || w_is_sw) w_next = S_MEM_ADDR;
                else if (w_is_r)        w_next = S_EXEC_R;
                else if (w_is_ialu)     w_next = S_EXEC_I;
                else if (w_is_br)       w_next = S_BRANCH;
                else begin
                    w_illegal = 1'b1;
                    w_next    = S_FETCH;
                end
            end
            S_MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_alu_op    = w_aop;
                if (w_is_lw) w_next = S_MEM_RD;
                else         w_next = S_MEM_WR;
            end
            S_MEM_RD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
                w_alu_op   = w_aop;
                if (mem_ready) w_next = S_MEM_WB;
                else           w_next = S_MEM_RD;
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_alu_op     = w_aop;
                w_next       = S_FETCH;
            end
            S_MEM_WR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                w_alu_op    = w_aop;
                if (mem_ready) w_next = S_FETCH;
                else           w_next = S_MEM_WR;
            end
            S_EXEC_R: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = w_aop;
                w_next      = S_WB_R;
            end
            S_WB_R: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
                w_alu_op    = w_aop;
                w_next      = S_FETCH;
            end
            S_EXEC_I: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_alu_op    = w_aop;
                w_next      = S_WB_I;
            end
            S_WB_I: begin
                w_reg_write = 1'b1;
                w_alu_op    = w_aop;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = w_aop;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
                w_branch_cond   = w_bc;
                w_next          = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // State register; r_run keeps every strobe low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_run   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (r_run) r_state <= w_next;
            else       r_state <= S_FETCH;
        end
    end

    assign pc_write      = r_run & w_pc_write;
    assign pc_write_cond = r_run & w_pc_write_cond;
    assign iord          = r_run & w_iord;
    assign mem_read      = r_run & w_mem_read;
    assign mem_write     = r_run & w_mem_write;
    assign ir_write      = r_run & w_ir_write;
    assign reg_dst       = r_run & w_reg_dst;
    assign mem_to_reg    = r_run & w_mem_to_reg;
    assign reg_write     = r_run & w_reg_write;
    assign alu_src_a     = r_run & w_alu_src_a;
    assign alu_src_b     = r_run ? w_alu_src_b   : 2'b00;
    assign pc_source     = r_run ? w_pc_source   : 2'b00;
    assign alu_op        = r_run ? w_alu_op      : 3'b000;
    assign branch_cond   = r_run ? w_branch_cond : 3'b000;
    assign illegal_op    = r_run & w_illegal;
    assign state_dbg     = r_state;

`ifdef MC_CTRL_INSTR_CNT_EN
    logic             w_retire;
    logic [CNT_W-1:0] r_instr_count;

    assign w_retire = r_run && (w_next == S_FETCH) &&
                      ((r_state == S_MEM_WB) || (r_state == S_MEM_WR) || (r_state == S_WB_R) ||
                       (r_state == S_WB_I)   || (r_state == S_BRANCH));

    // Retired-instruction counter; illegal instructions leave from DECODE and are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_count <= {CNT_W{1'b0}};
        end else if (w_retire) begin
            r_instr_count <= r_instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_instr_count <= r_instr_count;
        end
    end

    assign instr_count = r_instr_count;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: a driver queues the expected per-cycle control word
// derived from the instruction class; a negedge monitor pops and compares.
module tb_mc_control_fsm;

    typedef struct packed {
        logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
        logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0]  alu_src_b, pc_source;
        logic [2:0]  alu_op, branch_cond;
        logic        illegal_op;
        logic [3:0]  state;
        logic [31:0] cnt;
    } exp_t;

    localparam int C_ILL = 0, C_LW = 1, C_SW = 2, C_R = 3, C_I = 4, C_BR = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [4:0]  rt;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, pc_source;
    logic [2:0]  alu_op, branch_cond;
    logic [3:0]  state_dbg;
`ifdef MC_CTRL_INSTR_CNT_EN
    logic [31:0] instr_count;
`endif

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] mcnt = 32'd0;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .rt(rt), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .alu_op(alu_op), .branch_cond(branch_cond), .illegal_op(illegal_op),
        .state_dbg(state_dbg)
`ifdef MC_CTRL_INSTR_CNT_EN
        , .instr_count(instr_count)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    always @(negedge clk) begin
        exp_t e, a;
        cyc = cyc + 1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = e;
            a.pc_write = pc_write;     a.pc_write_cond = pc_write_cond; a.iord = iord;
            a.mem_read = mem_read;     a.mem_write = mem_write;         a.ir_write = ir_write;
            a.reg_dst = reg_dst;       a.mem_to_reg = mem_to_reg;       a.reg_write = reg_write;
            a.alu_src_a = alu_src_a;   a.alu_src_b = alu_src_b;         a.pc_source = pc_source;
            a.alu_op = alu_op;         a.branch_cond = branch_cond;     a.illegal_op = illegal_op;
            a.state = state_dbg;
`ifdef MC_CTRL_INSTR_CNT_EN
            a.cnt = instr_count;
`endif
            checks = checks + 1;
            if (a !== e) begin
                errors = errors + 1;
                $display("FAIL ctrl_word cycle %0d op=%b rt=%b: got %h required %h",
                         cyc, opcode, rt, a, e);
            end
        end
    end

    // Reference classification straight from the opcode map.
    function automatic int classify(input logic [5:0] op, input logic [4:0] r,
                                    output logic [2:0] aop, output logic [2:0] bc);
        aop = 3'b000;
        bc  = 3'b000;
        if (op == 6'b100011) return C_LW;
        if (op == 6'b101011) return C_SW;
        if (op == 6'b000000) begin aop = 3'b010; return C_R; end
        if (op == 6'b001000) begin aop = 3'b011; return C_I; end
        if (op == 6'b001100) begin aop = 3'b100; return C_I; end
        if (op == 6'b001101) begin aop = 3'b101; return C_I; end
        aop = 3'b001;
        if (op == 6'b000100) begin bc = 3'b001; return C_BR; end
        if (op == 6'b000101) begin bc = 3'b010; return C_BR; end
        if (op == 6'b000001) begin bc = 3'b011; return C_BR; end
        if (op == 6'b000110) begin bc = 3'b101; return C_BR; end
        if (op == 6'b000111 && r == 5'd1) begin bc = 3'b100; return C_BR; end
        if (op == 6'b000011 && r == 5'd0) begin bc = 3'b110; return C_BR; end
        aop = 3'b000;
        return C_ILL;
    endfunction

    task automatic step(input logic mr, input exp_t e);
        mem_ready = mr;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t idle();
        exp_t z;
        z = '0;
        return z;
    endfunction

    // One instruction; abort_rd asserts reset after one MEM_RD stall of a load.
    task automatic issue(input logic [5:0] op, input logic [4:0] r, input int fst,
                         input int mst, input bit abort_rd);
        exp_t e, b;
        int cls;
        logic [2:0] aop, bc;
        opcode = op;
        rt     = r;
        e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.cnt = mcnt;
        for (int k = 0; k < fst; k++) step(1'b0, e);
        e.ir_write = 1'b1; e.pc_write = 1'b1;
        step(1'b1, e);
        cls = classify(op, r, aop, bc);
        b = '0; b.alu_op = aop; b.branch_cond = bc; b.cnt = mcnt;
        e = b; e.state = 4'd1; e.alu_src_b = 2'b11; e.illegal_op = (cls == C_ILL);
        step(1'($urandom_range(0, 1)), e);
        if (cls == C_LW || cls == C_SW) begin
            e = b; e.state = 4'd2; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
            step(1'($urandom_range(0, 1)), e);
        end
        if (cls == C_LW) begin
            e = b; e.state = 4'd3; e.mem_read = 1'b1; e.iord = 1'b1;
            if (abort_rd) begin
                step(1'b0, e);
                rst_n = 1'b0;
                mcnt  = 32'd0;
                step(1'b1, idle());
                step(1'b0, idle());
                rst_n = 1'b1;
                step(1'b1, idle());
                return;
            end
            for (int k = 0; k < mst; k++) step(1'b0, e);
            step(1'b1, e);
            e = b; e.state = 4'd4; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
            step(1'($urandom_range(0, 1)), e);
        end else if (cls == C_SW) begin
            e = b; e.state = 4'd5; e.mem_write = 1'b1; e.iord = 1'b1;
            for (int k = 0; k < mst; k++) step(1'b0, e);
            step(1'b1, e);
        end else if (cls == C_R) begin
            e = b; e.state = 4'd6; e.alu_src_a = 1'b1;
            step(1'($urandom_range(0, 1)), e);
            e = b; e.state = 4'd7; e.reg_write = 1'b1; e.reg_dst = 1'b1;
            step(1'($urandom_range(0, 1)), e);
        end else if (cls == C_I) begin
            e = b; e.state = 4'd8; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
            step(1'($urandom_range(0, 1)), e);
            e = b; e.state = 4'd9; e.reg_write = 1'b1;
            step(1'($urandom_range(0, 1)), e);
        end else if (cls == C_BR) begin
            e = b; e.state = 4'd10; e.alu_src_a = 1'b1; e.pc_write_cond = 1'b1;
            e.pc_source = 2'b01;
            step(1'($urandom_range(0, 1)), e);
        end
        if (cls != C_ILL) mcnt = mcnt + 32'd1;
    endtask

    logic [5:0] ops [12] = '{6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b100011, 6'b101011,
                             6'b000100, 6'b000101, 6'b000001, 6'b000110, 6'b000111, 6'b000011};

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'b000000;
        rt        = 5'd0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) step(1'b1, idle());
        rst_n = 1'b1;
        step(1'b1, idle());

        issue(6'b100011, 5'd0, 0, 0, 1'b0);
        issue(6'b101011, 5'd7, 0, 3, 1'b0);
        issue(6'b000011, 5'd0, 0, 0, 1'b0);
        issue(6'b000011, 5'd2, 0, 0, 1'b0);
        issue(6'b001100, 5'd3, 0, 0, 1'b0);
        issue(6'b001101, 5'd9, 0, 0, 1'b0);
        issue(6'b000111, 5'd1, 1, 0, 1'b0);
        issue(6'b000111, 5'd0, 0, 0, 1'b0);
        issue(6'b111111, 5'd0, 2, 0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            int pick;
            logic [5:0] op;
            pick = $urandom_range(0, 12);
            if (pick == 12) op = 6'($urandom);
            else            op = ops[pick];
            issue(op, 5'($urandom_range(0, 3)), $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
        end

        issue(6'b100011, 5'd0, 1, 0, 1'b1);
        issue(6'b000000, 5'd0, 0, 0, 1'b0);
        issue(6'b100011, 5'd0, 0, 2, 1'b0);

        checks = checks + 1;
        if (sb_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d pending entries required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
